// File: rtl/sparc_exu_byp_ecccheck.sv
// Two-stage SEC-DED checker/corrector for the EXU register-file read path.
// Stage 1 registers the recomputed syndrome; stage 2 decodes, corrects, and maintains the error log and CE counter.
module sparc_exu_byp_ecccheck #(
   parameter int TAG_W = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [63:0]      in_data,
   input  logic [7:0]       in_chk,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_vld,
   output logic [63:0]      out_data,
   output logic             out_ce,
   output logic             out_ue,
   output logic [7:0]       out_syn,
   output logic             log_vld,
   output logic             log_ue,
   output logic [7:0]       log_syn,
   output logic [TAG_W-1:0] log_tag,
   input  logic             log_clr,
   output logic [CNT_W-1:0] ce_cnt
);

   // Hamming position of data bit idx: the (idx+1)-th integer >= 3 that is not a power of two.
   function automatic logic [6:0] pos_of(input int idx);
      int c;
      logic [6:0] r;
      c = 0;
      r = '0;
      for (int p = 3; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (c == idx) r = p[6:0];
            c++;
         end
      end
      return r;
   endfunction

   logic [6:0][63:0] cov;
   logic [6:0][7:0]  grp;
   logic [7:0]       par_grp;
   logic [7:0]       syn_next;
   logic [63:0]      flip;

   logic             s1_vld;
   logic [63:0]      s1_data;
   logic [7:0]       s1_syn;
   logic [TAG_W-1:0] s1_tag;

   logic             dec_ce;
   logic             dec_ue;
   logic             dec_err;
   logic [63:0]      corr_data;

   genvar gi, gj, gk;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_bit
         localparam logic [6:0] POS = pos_of(gi);
         for (gj = 0; gj < 7; gj++) begin : g_cov
            assign cov[gj][gi] = POS[gj];
         end
         assign flip[gi] = s1_syn[7] && (s1_syn[6:0] == POS);
      end

      // Each check bit is an XOR of eight 8-input groups, keeping tree depth shallow ahead of the flop.
      for (gj = 0; gj < 7; gj++) begin : g_chk
         for (gk = 0; gk < 8; gk++) begin : g_grp
            assign grp[gj][gk] = ^(in_data[gk*8 +: 8] & cov[gj][gk*8 +: 8]);
         end
         assign syn_next[gj] = in_chk[gj] ^ (^grp[gj]);
      end

      for (gk = 0; gk < 8; gk++) begin : g_par
         assign par_grp[gk] = ^in_data[gk*8 +: 8];
      end
   endgenerate

   assign syn_next[7] = (^par_grp) ^ (^in_chk);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_data <= '0;
         s1_syn  <= '0;
         s1_tag  <= '0;
      end else begin
         s1_vld  <= in_vld;
         s1_data <= in_data;
         s1_syn  <= syn_next;
         s1_tag  <= in_tag;
      end
   end

   // Odd overall parity with s[6:0] <= 71 is a single-bit error (data or check bit); anything else nonzero is UE.
   always_comb begin
      dec_ce    = s1_vld && s1_syn[7] && (s1_syn[6:0] <= 7'd71);
      dec_ue    = s1_vld && (s1_syn[7] ? (s1_syn[6:0] > 7'd71) : (s1_syn[6:0] != 7'd0));
      dec_err   = dec_ce || dec_ue;
      corr_data = s1_data ^ flip;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_ce   <= 1'b0;
         out_ue   <= 1'b0;
         out_syn  <= '0;
      end else begin
         out_vld  <= s1_vld;
         out_data <= corr_data;
         out_ce   <= dec_ce;
         out_ue   <= dec_ue;
         out_syn  <= s1_vld ? s1_syn : 8'h00;
      end
   end

   // A clear coinciding with a new error still captures it; a UE may replace a logged CE exactly once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         log_vld <= 1'b0;
         log_ue  <= 1'b0;
         log_syn <= '0;
         log_tag <= '0;
      end else if (dec_err && (!log_vld || log_clr || (dec_ue && !log_ue))) begin
         log_vld <= 1'b1;
         log_ue  <= dec_ue;
         log_syn <= s1_syn;
         log_tag <= s1_tag;
      end else if (log_clr) begin
         log_vld <= 1'b0;
         log_ue  <= 1'b0;
         log_syn <= '0;
         log_tag <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_cnt <= '0;
      end else if (dec_ce && (ce_cnt != {CNT_W{1'b1}})) begin
         ce_cnt <= ce_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_sparc_exu_byp_ecccheck.sv
// Randomized and directed bench for the SEC-DED checker, compared against a position-arithmetic reference model.
module tb_sparc_exu_byp_ecccheck;

   localparam int TAG_W = 7;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_vld;
   logic [63:0]      in_data;
   logic [7:0]       in_chk;
   logic [TAG_W-1:0] in_tag;
   logic             out_vld;
   logic [63:0]      out_data;
   logic             out_ce;
   logic             out_ue;
   logic [7:0]       out_syn;
   logic             log_vld;
   logic             log_ue;
   logic [7:0]       log_syn;
   logic [TAG_W-1:0] log_tag;
   logic             log_clr;
   logic [CNT_W-1:0] ce_cnt;

   sparc_exu_byp_ecccheck #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_chk(in_chk),
      .in_tag(in_tag), .out_vld(out_vld), .out_data(out_data), .out_ce(out_ce),
      .out_ue(out_ue), .out_syn(out_syn), .log_vld(log_vld), .log_ue(log_ue),
      .log_syn(log_syn), .log_tag(log_tag), .log_clr(log_clr), .ce_cnt(ce_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int pos_t[64];

   // reference model state
   logic             m1_vld;
   logic [63:0]      m1_data;
   logic [7:0]       m1_chk;
   logic [TAG_W-1:0] m1_tag;
   logic             e_vld, e_ce, e_ue, e_log_vld, e_log_ue;
   logic [63:0]      e_data;
   logic [7:0]       e_syn, e_log_syn;
   logic [TAG_W-1:0] e_log_tag;
   int               e_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [63:0] d);
      logic [6:0] p;
      int v;
      p = '0;
      for (int i = 0; i < 64; i++) begin
         v = pos_t[i];
         if (d[i]) p = p ^ v[6:0];
      end
      return {(^d) ^ (^p), p};
   endfunction

   task automatic model_reset();
      m1_vld = 0; m1_data = '0; m1_chk = '0; m1_tag = '0;
      e_vld = 0; e_ce = 0; e_ue = 0; e_data = '0; e_syn = '0;
      e_log_vld = 0; e_log_ue = 0; e_log_syn = '0; e_log_tag = '0; e_cnt = 0;
   endtask

   // One clock edge of the reference: finish the read sampled last edge, then sample the current inputs.
   task automatic model_edge();
      logic [7:0] s;
      logic [63:0] d;
      logic ce, ue;
      int v;
      s = {1'b0, m1_chk[6:0]};
      for (int i = 0; i < 64; i++) begin
         v = pos_t[i];
         if (m1_data[i]) s[6:0] = s[6:0] ^ v[6:0];
      end
      s[7] = ^{m1_data, m1_chk};
      d = m1_data; ce = 0; ue = 0;
      if (s[7]) begin
         if (s[6:0] > 7'd71) ue = 1;
         else begin
            ce = 1;
            for (int i = 0; i < 64; i++) if (pos_t[i] == int'(s[6:0])) d[i] = ~d[i];
         end
      end else if (s[6:0] != 0) ue = 1;
      if (!m1_vld) begin ce = 0; ue = 0; s = '0; end
      e_vld = m1_vld; e_data = d; e_ce = ce; e_ue = ue; e_syn = s;
      if (log_clr) begin
         e_log_vld = 0; e_log_ue = 0; e_log_syn = '0; e_log_tag = '0;
      end
      if ((ce || ue) && (!e_log_vld || (ue && !e_log_ue))) begin
         e_log_vld = 1; e_log_ue = ue; e_log_syn = s; e_log_tag = m1_tag;
      end
      if (ce && e_cnt < 255) e_cnt++;
      m1_vld = in_vld; m1_data = in_data; m1_chk = in_chk; m1_tag = in_tag;
   endtask

   task automatic check_all();
      chk("out_vld", out_vld, e_vld);
      if (e_vld) chk("out_data", out_data, e_data);
      chk("out_ce", out_ce, e_ce);
      chk("out_ue", out_ue, e_ue);
      chk("out_syn", out_syn, e_syn);
      chk("log_vld", log_vld, e_log_vld);
      chk("log_ue", log_ue, e_log_ue);
      chk("log_syn", log_syn, e_log_syn);
      chk("log_tag", log_tag, e_log_tag);
      chk("ce_cnt", ce_cnt, e_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c,
                        input logic [TAG_W-1:0] t, input logic clr);
      in_vld = v; in_data = d; in_chk = c; in_tag = t; log_clr = clr;
   endtask

   task automatic one(input logic [63:0] d, input logic [7:0] c, input logic [TAG_W-1:0] t);
      drive(1'b1, d, c, t, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      $display("read data=%h chk=%h -> out=%h syn=%h ce=%0d ue=%0d cnt=%0d",
               d, c, out_data, out_syn, out_ce, out_ue, ce_cnt);
   endtask

   logic [63:0]      clean, prev_clean, rd;
   logic [TAG_W-1:0] tg, prev_tag, held_tag;
   int               b;

   initial begin
      for (int i = 0, c = 0, p = 3; i < 64; p++) begin
         if ((p & (p - 1)) != 0) begin pos_t[i] = p; i++; c++; end
      end
      model_reset();
      rst = 1'b1;
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_out_data", out_data, 64'h0);
      rst = 1'b0;

      // directed reads
      one(64'h0, 8'h00, 7'd1);
      chk("zero_syn", out_syn, 8'h00);
      chk("zero_vld", out_vld, 1'b1);
      chk("zero_log", log_vld, 1'b0);
      one(64'h1, 8'h00, 7'd2);
      chk("d0_data", out_data, 64'h0);
      chk("d0_syn", out_syn, 8'h83);
      chk("d0_ce", out_ce, 1'b1);
      chk("d0_logsyn", log_syn, 8'h83);
      chk("d0_cnt", ce_cnt, 8'd1);
      one(64'h8000_0000_0000_0000, 8'h00, 7'd3);
      chk("d63_syn", out_syn, 8'hC7);
      chk("d63_data", out_data, 64'h0);
      one(64'h0, 8'h01, 7'd4);
      chk("p0_syn", out_syn, 8'h81);
      chk("p0_ce", out_ce, 1'b1);
      chk("p0_logsyn", log_syn, 8'h83);
      one(64'h3, 8'h00, 7'd5);
      chk("dbl_syn", out_syn, 8'h06);
      chk("dbl_ue", out_ue, 1'b1);
      chk("dbl_data", out_data, 64'h3);
      chk("dbl_logue", log_ue, 1'b1);
      chk("dbl_logsyn", log_syn, 8'h06);
      chk("dbl_cnt", ce_cnt, 8'd3);
      drive(1'b0, '0, '0, '0, 1'b1);
      tick();
      chk("clr_log", log_vld, 1'b0);

      // back-to-back single-bit data errors; log_clr lands on a completing error at n==150
      prev_clean = '0; prev_tag = '0; held_tag = '0;
      for (int n = 0; n < 300; n++) begin
         clean = {$urandom, $urandom};
         b = $urandom_range(63);
         rd = clean ^ (64'h1 << b);
         tg = TAG_W'($urandom);
         drive(1'b1, rd, enc(clean), tg, n == 150);
         if (n == 150) held_tag = prev_tag;
         tick();
         if (n >= 1) chk("corr_vs_clean", out_data, prev_clean);
         if (n == 150) begin
            chk("clr_cap_vld", log_vld, 1'b1);
            chk("clr_cap_tag", log_tag, held_tag);
         end
         $display("txn %0d tag=%0d flip=%0d out=%h syn=%h cnt=%0d", n, tg, b, out_data, out_syn, ce_cnt);
         prev_clean = clean; prev_tag = tg;
      end
      drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      chk("last_corr", out_data, prev_clean);
      tick();
      chk("cnt_sat", ce_cnt, 8'd255);

      // asynchronous reset with reads in flight
      drive(1'b1, {$urandom, $urandom}, 8'h00, 7'd9, 1'b0);
      tick();
      drive(1'b1, 64'h1, 8'h00, 7'd10, 1'b0);
      tick();
      drive(1'b1, 64'h3, 8'h00, 7'd11, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("arst_data", out_data, 64'h0);
      $display("async reset: out_vld=%0d log_vld=%0d cnt=%0d", out_vld, log_vld, ce_cnt);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (3) tick();
      drive(1'b1, 64'h4, 8'h00, 7'd12, 1'b0);
      tick();
      chk("post_rst_lat1", out_vld, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      chk("post_rst_lat2", out_vld, 1'b1);
      chk("post_rst_data", out_data, 64'h0);
      chk("post_rst_syn", out_syn, 8'h86);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sparc_exu_byp_ecccheck.md
# sparc_exu_byp_ecccheck

Two-stage SEC-DED checker/corrector on the EXU register-file read path, consuming the 64-bit operand and the 8 check bits produced at write time by the bypass ECC generator. It recomputes the syndrome, corrects single-bit data errors, flags double/uncorrectable errors, and keeps a first-error log plus a correctable-error counter for trap/ASI reporting.

## Interface
- TAG_W, 7, width of the register/thread tag carried with each read
- CNT_W, 8, width of the saturating correctable-error counter
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- in_vld  in  1  read data valid this cycle
- in_data  in  64  raw data from register file
- in_chk  in  8  stored check bits p[7:0]
- in_tag  in  TAG_W  register address / thread id of this read
- out_vld  out  1  corrected result valid
- out_data  out  64  corrected data
- out_ce  out  1  correctable error on this result (data or check bit)
- out_ue  out  1  uncorrectable error on this result
- out_syn  out  8  syndrome of this result
- log_vld  out  1  error log holds a captured error (sticky)
- log_ue  out  1  captured error was uncorrectable
- log_syn  out  8  captured syndrome
- log_tag  out  TAG_W  captured tag
- log_clr  in  1  clears error log (single-cycle pulse)
- ce_cnt  out  CNT_W  count of correctable errors, saturating

## Operation
- H-matrix: data bit i occupies Hamming position pos(i) = (i+1)-th integer ≥3 that is not a power of two (d0→3, d1→5, d2→6, d3→7, d4→9, …, d63→71). Check bit p[k], k=0..6, covers data bits whose pos(i) has bit k set. p[7] makes the 72-bit codeword even parity.
- Stage 1 (registered): s[6:0] = in_chk[6:0] XOR recomputed p[6:0]; s[7] = XOR of all 64 data + 8 check bits. Register s, in_data, in_tag, in_vld. XOR trees split into ≤8-input groups; groups are XORed before the stage-1 flop.
- Stage 2 (registered outputs), decode of s:
  - s==0: no error, data passes.
  - s[7]=1, s[6:0]==pos(i): flip data bit i; out_ce=1.
  - s[7]=1, s[6:0]==0 or a power of two: check-bit error; data unchanged; out_ce=1.
  - s[7]=1, s[6:0] ∉ {0, powers of two, pos(0..63)} (i.e. >71): out_ue=1, data unchanged.
  - s[7]=0, s[6:0]!=0: double error; out_ue=1, data unchanged.
- out_ce/out_ue/out_syn valid only with out_vld; forced 0 when out_vld=0.
- Error log: on out_vld & (ce|ue) with log_vld=0, capture syn/tag/ue and set log_vld. While log_vld=1, later errors are not captured except a UE overwrites a logged CE (UE priority, once).
- log_clr clears log_vld/log_ue/log_syn/log_tag; if an error completes stage 2 in the same cycle as log_clr, the new error is captured (clear then capture).
- ce_cnt increments on each out_vld & out_ce, saturates at 2^CNT_W−1; cleared only by rst. UE does not count.

## Timing
- Latency 2 cycles: input at edge N → out_* valid after edge N+2. Full throughput, one result per cycle, no backpressure, no stall.
- Bubbles (in_vld=0) propagate as out_vld=0; stage registers still load (data don't-care).
- Log and counter update at the same edge out_vld rises for that result; visible the cycle after.
- Reset: all outputs 0 (out_vld, out_data, out_ce, out_ue, out_syn, log_*, ce_cnt); pipeline valids cleared asynchronously. Reset mid-pipeline discards in-flight reads; no output for them after rst deasserts.

## Test plan
- in_data=0, in_chk=0, in_vld=1 → two cycles later out_vld=1, out_data=0, out_ce=0, out_ue=0, out_syn=0x00; log_vld stays 0.
- Correct codeword for 0 with data bit 0 flipped (in_data=0x1, in_chk=0) → out_data=0, out_syn=0x83, out_ce=1; log_vld=1, log_syn=0x83; ce_cnt=1.
- in_data=0x8000_0000_0000_0000, in_chk=0 → out_data=0, out_syn=0xC7, out_ce=1; in_data=0, in_chk=0x01 → out_syn=0x81, out_ce=1, data 0.
- in_data=0x3, in_chk=0 → out_syn=0x06, out_ue=1, out_data=0x3; a CE logged earlier is overwritten with log_ue=1, log_syn=0x06; ce_cnt unchanged.
- Back-to-back 300 single-bit errors on random data with CNT_W=8 → every out_data corrected, ce_cnt saturates at 255; log_clr pulsed in the same cycle as an error completes → log_vld remains 1 holding that error's tag/syndrome.
- rst asserted asynchronously with two reads in flight → all outputs 0 immediately; after release, no out_vld until a new in_vld, first new result after 2 cycles.
